hex4_seg_scanner: RTL and testbench



---
 rtl/hex4_seg_scanner.sv | 72 +++++++
 tb/tb_hex4_seg_scanner.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hex4_seg_scanner.sv
// Four-digit multiplexed hex display driver for a common-anode 7-segment module.
// A free-running prescaler paces the digit scan; sel and seg are registered, active-low.
module hex4_seg_scanner #(
    parameter int unsigned SCAN_DIV_W = 15
) (
    input  logic        clk_50m,
    input  logic        rst_n,
    input  logic [15:0] number,
    input  logic [3:0]  dot,
    output logic [3:0]  sel,
    output logic [7:0]  seg
);

    logic [SCAN_DIV_W-1:0] presc_q, presc_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic                  scan_tick;
    logic [3:0]            nibble;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hexpat(input logic [3:0] v);
        logic [6:0] p;
        unique case (v)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            4'hF: p = 7'h71;
        endcase
        return p;
    endfunction

    always_comb begin
        presc_d   = presc_q + 1'b1;
        scan_tick = &presc_q;
        idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
        nibble    = number[{idx_q, 2'b00} +: 4];
        // Outputs follow the current index, so a digit change lands one cycle after scan_tick
        sel_d     = ~(4'b0001 << idx_q);
        seg_d     = ~{dot[idx_q], hexpat(nibble)};
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            sel_q   <= '1;
            seg_q   <= '1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_hex4_seg_scanner.sv
// Scoreboard bench for hex4_seg_scanner: a fast-scan instance checked every cycle
// against a cycle-count display model, plus a default-rate instance checked for dwell length.
module tb_hex4_seg_scanner;

    localparam int unsigned W = 2;

    typedef struct {
        logic [3:0]  sel;
        logic [7:0]  seg;
        int unsigned tag;
    } exp_t;

    logic        clk_50m = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_def_n = 1'b0;
    logic [15:0] number = 16'h0000;
    logic [3:0]  dot = 4'b0000;
    logic [3:0]  sel;
    logic [7:0]  seg;
    logic [15:0] num_def = 16'hB7E5;
    logic [3:0]  dot_def = 4'b0010;
    logic [3:0]  sel_def;
    logic [7:0]  seg_def;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned n = 0;
    int unsigned last_k = 0;
    bit          in_rst = 1'b1;
    bit          def_done = 1'b0;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex4_seg_scanner #(.SCAN_DIV_W(W)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .number(number), .dot(dot), .sel(sel), .seg(seg)
    );

    hex4_seg_scanner dut_def (
        .clk_50m(clk_50m), .rst_n(rst_def_n), .number(num_def), .dot(dot_def),
        .sel(sel_def), .seg(seg_def)
    );

    always #10 clk_50m = ~clk_50m;

    function automatic logic [7:0] seg_of(input logic [15:0] num, input logic [3:0] d,
                                          input int unsigned k);
        int unsigned nib;
        int unsigned v;
        nib = (int'(num) >> (4 * k)) & 15;
        v   = 255 - ((d[k] ? 128 : 0) + int'(hex_tab[nib]));
        return v[7:0];
    endfunction

    // Expected display for the coming edge: edge n after release shows digit ((n-1)/2^W) mod 4
    task automatic push_exp();
        exp_t        e;
        int unsigned k;
        int unsigned s;
        if (in_rst) begin
            e.sel = 4'hF;
            e.seg = 8'hFF;
            e.tag = 0;
        end else begin
            n++;
            k      = ((n - 1) >> W) % 4;
            last_k = k;
            s      = 15 - (1 << k);
            e.sel  = s[3:0];
            e.seg  = seg_of(number, dot, k);
            e.tag  = n;
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic [15:0] num, input logic [3:0] d, input bit rel);
        @(negedge clk_50m);
        number = num;
        dot    = d;
        if (rel) begin
            rst_n  = 1'b1;
            in_rst = 1'b0;
            n      = 0;
        end
        push_exp();
    endtask

    always @(posedge clk_50m or negedge rst_n) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (sel !== e.sel || seg !== e.seg) begin
                failures++;
                $display("FAIL scan tag=%0d sel got=%b exp=%b seg got=%h exp=%h",
                         e.tag, sel, e.sel, seg, e.seg);
            end
        end
    end

    initial begin : def_check
        logic [3:0] prev;
        int         changes;
        repeat (2) @(negedge clk_50m);
        rst_def_n = 1'b1;
        changes   = 0;
        prev      = 4'hF;
        for (int c = 1; c <= 32769; c++) begin
            @(posedge clk_50m);
            #1;
            if (c == 1) begin
                checks++;
                if (sel_def !== 4'b1110 || seg_def !== seg_of(num_def, dot_def, 0)) begin
                    failures++;
                    $display("FAIL def_first sel got=%b exp=1110 seg got=%h exp=%h",
                             sel_def, seg_def, seg_of(num_def, dot_def, 0));
                end
            end else if (sel_def !== prev) begin
                changes++;
            end
            if (c == 32768) begin
                checks++;
                if (changes != 0 || sel_def !== 4'b1110) begin
                    failures++;
                    $display("FAIL def_dwell changes got=%0d exp=0 sel got=%b exp=1110",
                             changes, sel_def);
                end
            end
            if (c == 32769) begin
                checks++;
                if (sel_def !== 4'b1101 || seg_def !== seg_of(num_def, dot_def, 1)) begin
                    failures++;
                    $display("FAIL def_switch sel got=%b exp=1101 seg got=%h exp=%h",
                             sel_def, seg_def, seg_of(num_def, dot_def, 1));
                end
            end
            prev = sel_def;
        end
        def_done = 1'b1;
    end

    initial begin : stim
        logic [31:0] r;
        logic [3:0]  v;
        int          guard;

        repeat (3) step(16'h12AF, 4'b0000, 1'b0);

        // Fixed digit scan, then wrap
        step(16'h12AF, 4'b0000, 1'b1);
        repeat (19) step(16'h12AF, 4'b0000, 1'b0);

        // Decimal points on digits 0 and 2
        repeat (16) step(16'h0000, 4'b0101, 1'b0);

        // Every hex value on every digit
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            r = $urandom();
            step({v, v, v, v}, r[3:0], 1'b0);
        end

        // Random values changing mid-digit
        for (int i = 0; i < 150; i++) begin
            r = $urandom();
            step(r[15:0], r[19:16], 1'b0);
        end

        // Asynchronous reset while digit 2 is lit
        guard = 0;
        do begin
            r = $urandom();
            step(r[15:0], r[19:16], 1'b0);
            guard++;
        end while (last_k != 2 && guard < 32);
        @(posedge clk_50m);
        #3;
        in_rst = 1'b1;
        sb.push_back('{sel: 4'hF, seg: 8'hFF, tag: 0});
        rst_n = 1'b0;
        repeat (2) step(r[15:0], r[19:16], 1'b0);
        r = $urandom();
        step(r[15:0], r[19:16], 1'b1);
        for (int i = 0; i < 40; i++) begin
            r = $urandom();
            step(r[15:0], r[19:16], 1'b0);
        end

        repeat (3) @(posedge clk_50m);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending got=%0d exp=0", sb.size());
        end

        for (int i = 0; i < 40000 && !def_done; i++) @(posedge clk_50m);
        if (!def_done) begin
            checks++;
            failures++;
            $display("FAIL def_timeout done got=0 exp=1");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
